// File: rtl/pps_monitor.sv
// PPS receive monitor: synchronises pps_in, timestamps each rising edge on a
// free-running 64-bit counter, measures the edge interval and tracks lock.
module pps_monitor #(
    parameter int unsigned NOMINAL_PERIOD = 1000000,
    parameter int unsigned TOLERANCE      = 100,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,
    input  logic        pps_in,
    input  logic        irq_ack,
    output logic        irq,
    output logic        overrun,
    output logic        locked,
    output logic [63:0] timestamp,
    output logic [31:0] period,
    output logic [31:0] seconds,
    output logic [15:0] missing_count
);

    localparam logic [31:0] P_NOM  = 32'(NOMINAL_PERIOD);
    localparam logic [31:0] P_LO   = 32'(NOMINAL_PERIOD - TOLERANCE);
    localparam logic [31:0] P_HI   = 32'(NOMINAL_PERIOD + TOLERANCE);
    localparam logic [31:0] P_LATE = 32'(NOMINAL_PERIOD + TOLERANCE + 1);
    localparam logic [31:0] P_DROP = 32'(4 * NOMINAL_PERIOD);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_ACQUIRE,
        S_LOCKED,
        S_HOLDOVER
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic [63:0]            r_cycle_count;
    logic [31:0]            r_interval;
    logic [63:0]            r_timestamp;
    logic [31:0]            r_period;
    state_t                 r_state;
    logic                   r_locked;
    logic [31:0]            r_seconds;
    logic [15:0]            r_missing;
    logic [31:0]            r_hold_cnt;
    logic                   r_irq;
    logic                   r_overrun;

    logic                   w_edge;
    logic                   w_in_tol;
    logic                   w_late;
    logic [15:0]            w_missing_inc;

    assign w_edge        = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign w_in_tol      = (r_interval >= P_LO) && (r_interval <= P_HI);
    assign w_late        = (r_interval == P_LATE) && !w_edge;
    assign w_missing_inc = (r_missing == '1) ? r_missing : r_missing + 16'd1;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_sync        <= '0;
            r_dly         <= 1'b0;
            r_cycle_count <= '0;
            r_interval    <= '0;
            r_timestamp   <= '0;
            r_period      <= '0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], pps_in};
            r_dly         <= r_sync[SYNC_STAGES-1];
            r_cycle_count <= r_cycle_count + 64'd1;
            if (w_edge) begin
                r_period    <= r_interval;
                r_interval  <= 32'd1;
                r_timestamp <= r_cycle_count;
            end else if (r_interval != '1) begin
                r_interval <= r_interval + 32'd1;
            end
        end
    end

    // r_hold_cnt counts cycles since the last missed-pulse decision in HOLDOVER,
    // so each further NOMINAL_PERIOD silent cycles adds one missing pulse.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state    <= S_SEARCH;
            r_locked   <= 1'b0;
            r_seconds  <= '0;
            r_missing  <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                S_SEARCH: begin
                    if (w_edge) begin
                        r_state <= S_ACQUIRE;
                    end
                end
                S_ACQUIRE: begin
                    if (w_edge) begin
                        if (w_in_tol) begin
                            r_state   <= S_LOCKED;
                            r_locked  <= 1'b1;
                            r_seconds <= r_seconds + 32'd1;
                        end
                    end else if (w_late) begin
                        r_state <= S_SEARCH;
                    end
                end
                S_LOCKED: begin
                    if (w_edge) begin
                        if (w_in_tol) begin
                            r_seconds <= r_seconds + 32'd1;
                        end else begin
                            r_state  <= S_ACQUIRE;
                            r_locked <= 1'b0;
                        end
                    end else if (w_late) begin
                        r_state    <= S_HOLDOVER;
                        r_locked   <= 1'b0;
                        r_missing  <= w_missing_inc;
                        r_hold_cnt <= 32'd1;
                    end
                end
                S_HOLDOVER: begin
                    if (w_edge) begin
                        r_state <= S_ACQUIRE;
                    end else if (r_interval == P_DROP) begin
                        r_state <= S_SEARCH;
                    end else if (r_hold_cnt == P_NOM) begin
                        r_missing  <= w_missing_inc;
                        r_hold_cnt <= 32'd1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state  <= S_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_irq     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_edge) begin
                r_irq <= 1'b1;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end
            if (w_edge && r_irq && !irq_ack) begin
                r_overrun <= 1'b1;
            end else if (irq_ack && !w_edge) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign irq           = r_irq;
    assign overrun       = r_overrun;
    assign locked        = r_locked;
    assign timestamp     = r_timestamp;
    assign period        = r_period;
    assign seconds       = r_seconds;
    assign missing_count = r_missing;

endmodule

// File: tb/tb_pps_monitor.sv
// Scoreboard bench for pps_monitor: pulses push expected per-edge register
// sets; a monitor pops and compares whenever a new timestamp is presented.
module tb_pps_monitor;

    localparam int unsigned NOM = 1000;
    localparam int unsigned TOL = 10;
    localparam int unsigned SS  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pps = 1'b0;
    logic        ack = 1'b0;
    logic        irq;
    logic        overrun;
    logic        locked;
    logic [63:0] timestamp;
    logic [31:0] period;
    logic [31:0] seconds;
    logic [15:0] missing_count;

    pps_monitor #(
        .NOMINAL_PERIOD(NOM),
        .TOLERANCE     (TOL),
        .SYNC_STAGES   (SS)
    ) dut (
        .axi_aclk     (clk),
        .axi_areset   (rst),
        .pps_in       (pps),
        .irq_ack      (ack),
        .irq          (irq),
        .overrun      (overrun),
        .locked       (locked),
        .timestamp    (timestamp),
        .period       (period),
        .seconds      (seconds),
        .missing_count(missing_count)
    );

    always #5 clk = ~clk;

    // Reference cycle count: zero in reset, +1 per rising edge afterwards.
    longint unsigned tb_cc;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cc <= 0;
        else     tb_cc <= tb_cc + 1;
    end

    typedef struct {
        longint unsigned ts;
        bit              chk_per;
        int unsigned     per;
        bit              lk;
        int unsigned     sec;
        int unsigned     miss;
        bit              irq_e;
        bit              ovr_e;
    } exp_t;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    longint unsigned last_rise = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a changed timestamp marks a newly presented edge record.
    initial begin : monitor
        longint unsigned last_ts;
        exp_t            e;
        last_ts = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_ts = 0;
            end else if (timestamp != last_ts) begin
                last_ts = timestamp;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_edge actual_ts=%0d expected=none", timestamp);
                end else begin
                    e = sb.pop_front();
                    chk("timestamp", timestamp, e.ts);
                    if (e.chk_per) chk("period", period, e.per);
                    chk("locked", locked, e.lk);
                    chk("seconds", seconds, e.sec);
                    chk("missing_count", missing_count, e.miss);
                    chk("irq", irq, e.irq_e);
                    chk("overrun", overrun, e.ovr_e);
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input longint unsigned cc);
        int guard;
        guard = 0;
        while (tb_cc < cc && guard < 20000) begin
            step(1);
            guard++;
        end
        if (tb_cc != cc) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_until actual=%0d expected=%0d", tb_cc, cc);
        end
    endtask

    // mode 0: ack after the edge; 1: no ack; 2: ack in the edge cycle itself.
    task automatic pulse(input int unsigned gap, input bit chk_per, input int unsigned per,
                         input bit lk, input int unsigned sec, input int unsigned miss,
                         input bit irq_e, input bit ovr_e, input int mode);
        exp_t e;
        if (gap != 0) wait_until(last_rise + gap);
        last_rise = tb_cc;
        e.ts      = tb_cc + SS;
        e.chk_per = chk_per;
        e.per     = per;
        e.lk      = lk;
        e.sec     = sec;
        e.miss    = miss;
        e.irq_e   = irq_e;
        e.ovr_e   = ovr_e;
        sb.push_back(e);
        pps = 1'b1;
        step(2);
        if (mode == 2) ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(1);
        pps = 1'b0;
        if (mode == 0) begin
            ack = 1'b1;
            step(1);
            ack = 1'b0;
        end
    endtask

    task automatic ack_check(input string tag);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(10);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timestamp"}, timestamp, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_seconds"}, seconds, 0);
        chk({tag, "_missing"}, missing_count, 0);
    endtask

    initial begin : stim
        longint unsigned e_cc;
        rst = 1'b1;
        step(3);
        chk_all_zero("reset");
        rst = 1'b0;
        step(10);

        // Regular pulses: acquire, lock on second edge, seconds=4 on fifth
        pulse(0,    0, 0,    0, 0, 0, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 1, 0, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 2, 0, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 3, 0, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 4, 0, 1, 0, 0);

        // Omitted pulse: lock drops 1011 cycles after the last edge
        e_cc = last_rise + SS;
        wait_until(e_cc + 1011);
        chk("late_locked_before", locked, 1);
        chk("late_missing_before", missing_count, 0);
        step(1);
        chk("late_locked_after", locked, 0);
        chk("late_missing_after", missing_count, 1);
        pulse(2000, 1, 2000, 0, 4, 1, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 5, 1, 1, 0, 0);

        // Early pulse
        pulse(500,  1, 500,  0, 5, 1, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 6, 1, 1, 0, 0);

        // irq / overrun handling
        pulse(1000, 1, 1000, 1, 7, 1, 1, 0, 1);
        pulse(1000, 1, 1000, 1, 8, 1, 1, 1, 1);
        ack_check("ack_clear");
        pulse(1000, 1, 1000, 1, 9,  1, 1, 0, 1);
        pulse(1000, 1, 1000, 1, 10, 1, 1, 0, 2);
        chk("ack_same_irq_held", irq, 1);
        ack_check("ack_after_same");
        chk("sb_empty_a", sb.size(), 0);

        // Holdover sequence from a fresh lock
        do_reset();
        pulse(0,    0, 0,    0, 0, 0, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 1, 0, 1, 0, 0);
        e_cc = last_rise + SS;
        wait_until(e_cc + 1011);
        chk("hold_missing_0", missing_count, 0);
        step(1);
        chk("hold_missing_1", missing_count, 1);
        chk("hold_locked", locked, 0);
        wait_until(e_cc + 2011);
        chk("hold_missing_1b", missing_count, 1);
        step(1);
        chk("hold_missing_2", missing_count, 2);
        wait_until(e_cc + 3012);
        chk("hold_missing_3", missing_count, 3);
        wait_until(e_cc + 5000);
        chk("search_missing_3", missing_count, 3);

        // Async reset mid-period with live state, then reacquire
        pulse(6000, 1, 6000, 0, 1, 3, 1, 0, 1);
        step(300);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        step(2);
        rst = 1'b0;
        step(10);
        pulse(0,    0, 0,    0, 0, 0, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 1, 0, 1, 0, 0);
        pulse(1000, 1, 1000, 1, 2, 0, 1, 0, 0);
        step(20);
        chk("sb_empty_b", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
